// File: rtl/digit_entry_debounce_if.sv
// Digit handshake between the entry debouncer (master) and the lock FSM (slave).
// The debouncer offers digit_data/digit_valid and the consumer answers with digit_ready.
interface digit_entry_debounce_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] digit_data;
  logic              digit_valid;
  logic              digit_ready;

  modport master (
    output digit_data,
    output digit_valid,
    input  digit_ready
  );

  modport slave (
    input  digit_data,
    input  digit_valid,
    output digit_ready
  );
endinterface

// File: rtl/digit_entry_debounce.sv
// Debounces the enter key, synchronises the digit switches and captures one digit per press into a
// one-entry valid/ready buffer. Optional macro DIGIT_RANGE_CHECK_EN rejects digits above 9 (err_digit).
module digit_entry_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int DATA_W          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_n_raw,
  input  logic [DATA_W-1:0]     sw_raw,
  digit_entry_debounce_if.master digit,
  output logic                  key_pressed,
  output logic                  overrun,
  output logic                  err_digit
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic              key_meta_reg;
  logic              key_s_reg;
  logic [DATA_W-1:0] sw_meta_reg;
  logic [DATA_W-1:0] sw_s_reg;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              press_commit;
  logic              key_pressed_next;

  logic              commit_reg;
  logic [DATA_W-1:0] commit_data_reg;

  logic              valid_reg;
  logic              valid_next;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] data_next;
  logic              overrun_reg;
  logic              overrun_next;
  logic              range_ok;
  logic              err_next;

  // Two-flop synchronisers; key idles released (high).
  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta_reg <= 1'b1;
      key_s_reg    <= 1'b1;
      sw_meta_reg  <= '0;
      sw_s_reg     <= '0;
    end else begin
      key_meta_reg <= key_n_raw;
      key_s_reg    <= key_meta_reg;
      sw_meta_reg  <= sw_raw;
      sw_s_reg     <= sw_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    press_commit     = 1'b0;
    key_pressed_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!key_s_reg) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (key_s_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = PRESSED;
          cnt_next     = '0;
          press_commit = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      PRESSED: begin
        key_pressed_next = 1'b1;
        if (key_s_reg) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        key_pressed_next = 1'b1;
        if (!key_s_reg) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign key_pressed = key_pressed_next;

  // The press and its switch snapshot are registered once before reaching the buffer, which is
  // where the extra cycle of press-to-valid latency comes from.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_reg      <= 1'b0;
      commit_data_reg <= '0;
    end else begin
      commit_reg <= press_commit;
      if (press_commit) begin
        commit_data_reg <= sw_s_reg;
      end
    end
  end

`ifdef DIGIT_RANGE_CHECK_EN
  logic err_reg;

  assign range_ok = (commit_data_reg <= DATA_W'(9));

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign err_digit = err_reg;
`else
  assign range_ok  = 1'b1;
  assign err_digit = 1'b0;
`endif

  // One-entry buffer: a commit loads when empty or draining this cycle, otherwise it is dropped.
  always_comb begin
    valid_next   = valid_reg;
    data_next    = data_reg;
    overrun_next = 1'b0;
    err_next     = 1'b0;
    if (commit_reg) begin
      if (!range_ok) begin
        err_next = 1'b1;
        if (valid_reg && digit.digit_ready) begin
          valid_next = 1'b0;
        end
      end else if (!valid_reg || digit.digit_ready) begin
        valid_next = 1'b1;
        data_next  = commit_data_reg;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (valid_reg && digit.digit_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      valid_reg   <= valid_next;
      data_reg    <= data_next;
      overrun_reg <= overrun_next;
    end
  end

  assign digit.digit_valid = valid_reg;
  assign digit.digit_data  = data_reg;
  assign overrun           = overrun_reg;

endmodule

// File: tb/tb_digit_entry_debounce.sv
// Scoreboard bench for digit_entry_debounce: a run-length debounce model queues expected digits,
// a negedge monitor pops them on each accepted transfer and checks the status outputs every cycle.
module tb_digit_entry_debounce;
  localparam int D = 4;
  localparam int W = 4;
`ifdef DIGIT_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_n_raw = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic         key_pressed;
  logic         overrun;
  logic         err_digit;

  digit_entry_debounce_if #(.DATA_W(W)) dif ();

  digit_entry_debounce #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3),
    .DATA_W(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n_raw(key_n_raw),
    .sw_raw(sw_raw),
    .digit(dif),
    .key_pressed(key_pressed),
    .overrun(overrun),
    .err_digit(err_digit)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  bit           key_line[2] = '{1'b1, 1'b1};
  logic [W-1:0] sw_line[2] = '{'0, '0};
  bit           m_pressed = 1'b0;
  int           run = 0;
  bit           pend = 1'b0;
  logic [W-1:0] pend_val = '0;
  bit           m_valid = 1'b0;
  bit           exp_ovr = 1'b0;
  bit           exp_err = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: a level change is accepted after D consecutive synchronised samples of the new level;
  // a press reaches the buffer one cycle later.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_q.delete();
        key_line  = '{1'b1, 1'b1};
        sw_line   = '{'0, '0};
        m_pressed = 1'b0;
        run       = 0;
        pend      = 1'b0;
        m_valid   = 1'b0;
        exp_ovr   = 1'b0;
        exp_err   = 1'b0;
      end else begin
        exp_ovr = 1'b0;
        exp_err = 1'b0;
        if (pend) begin
          if (RANGE_EN && pend_val > 4'd9) begin
            exp_err = 1'b1;
            if (m_valid && dif.digit_ready) m_valid = 1'b0;
          end else if (!m_valid || dif.digit_ready) begin
            m_valid = 1'b1;
            exp_q.push_back(pend_val);
          end else begin
            exp_ovr = 1'b1;
          end
        end else if (m_valid && dif.digit_ready) begin
          m_valid = 1'b0;
        end
        pend = 1'b0;
        if ((key_line[1] == 1'b0) == m_pressed) begin
          run = 0;
        end else begin
          run++;
          if (run == D) begin
            m_pressed = !m_pressed;
            run = 0;
            if (m_pressed) begin
              pend     = 1'b1;
              pend_val = sw_line[1];
            end
          end
        end
        key_line[1] = key_line[0];
        key_line[0] = key_n_raw;
        sw_line[1]  = sw_line[0];
        sw_line[0]  = sw_raw;
      end
    end
  end

  // Monitor
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("digit_valid", dif.digit_valid, m_valid);
      check("key_pressed", key_pressed, m_pressed);
      check("overrun", overrun, exp_ovr);
      check("err_digit", err_digit, exp_err);
      if (!reset && dif.digit_valid === 1'b1 && dif.digit_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer: got digit %0d expected none at %0t", dif.digit_data, $time);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          $display("transfer digit=%0d expected=%0d t=%0t", dif.digit_data, e, $time);
          check("digit_data", dif.digit_data, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [W-1:0] v, input int hold, input int rel);
    sw_raw = v;
    key_n_raw = 1'b0;
    tick(hold);
    key_n_raw = 1'b1;
    tick(rel);
  endtask

  initial begin
    dif.digit_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    check("reset_digit_data", dif.digit_data, 0);

    // Clean press, held, then consumed for one cycle
    sw_raw = 4'd8;
    key_n_raw = 1'b0;
    tick(10);
    dif.digit_ready = 1'b1;
    tick(1);
    dif.digit_ready = 1'b0;
    key_n_raw = 1'b1;
    tick(10);

    // Bounce rejected, then clean press of 3
    key_n_raw = 1'b0; tick(2);
    key_n_raw = 1'b1; tick(1);
    key_n_raw = 1'b0; tick(2);
    key_n_raw = 1'b1; tick(8);
    press(4'd3, 10, 10);
    dif.digit_ready = 1'b1;
    tick(2);
    dif.digit_ready = 1'b0;

    // Overrun: second press dropped while full
    press(4'd8, 8, 8);
    press(4'd4, 8, 8);
    dif.digit_ready = 1'b1;
    tick(3);
    dif.digit_ready = 1'b0;

    // Accept and reload on the same edge
    press(4'd2, 8, 8);
    sw_raw = 4'd5;
    key_n_raw = 1'b0;
    tick(6);
    dif.digit_ready = 1'b1;
    tick(1);
    dif.digit_ready = 1'b0;
    tick(4);
    key_n_raw = 1'b1;
    tick(8);
    dif.digit_ready = 1'b1;
    tick(2);
    dif.digit_ready = 1'b0;

    // Reset mid-debounce with a digit pending
    press(4'd7, 8, 8);
    key_n_raw = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(10);
    key_n_raw = 1'b1;
    tick(8);
    dif.digit_ready = 1'b1;
    tick(2);

    // Out-of-range digit
    dif.digit_ready = 1'b0;
    press(4'd12, 8, 8);
    dif.digit_ready = 1'b1;
    tick(3);

    // Randomised phase
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) reset = 1'b1;
      else reset = 1'b0;
      if ($urandom_range(0, 3) == 0) key_n_raw = ~key_n_raw;
      if ($urandom_range(0, 2) == 0) sw_raw = W'($urandom);
      dif.digit_ready = ($urandom_range(0, 2) == 0);
      tick($urandom_range(1, 3));
    end
    for (int i = 0; i < 20; i++) begin
      reset = 1'b0;
      key_n_raw = 1'b0;
      sw_raw = W'($urandom);
      dif.digit_ready = ($urandom_range(0, 1) == 1);
      tick($urandom_range(D + 3, D + 8));
      key_n_raw = 1'b1;
      tick($urandom_range(D + 3, D + 8));
    end

    // Drain
    reset = 1'b0;
    key_n_raw = 1'b1;
    dif.digit_ready = 1'b1;
    tick(30);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_entry_debounce.md
Name: digit_entry_debounce

Overview:
- Upstream stage of the combination-lock FSM on the DE1-SoC board.
- Runs on the 50 MHz board clock.
- Synchronises and debounces the raw active-low "enter" pushbutton and synchronises the digit switches.
- On each debounced press, captures the switch value into a one-entry buffer and offers it downstream on a valid/ready handshake. The lock FSM then advances one state per accepted digit instead of being clocked directly by the button.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); minimum legal value 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- DATA_W, 4, digit width.

Ports:
- clk  input  1  board clock.
- reset  input  1  synchronous, active-high reset.
- key_n_raw  input  1  raw pushbutton, low = pressed, asynchronous, bouncy.
- sw_raw  input  DATA_W  raw switch value, asynchronous.
- digit_data  output  DATA_W  captured digit; stable while digit_valid=1.
- digit_valid  output  1  buffer holds an unconsumed digit.
- digit_ready  input  1  consumer accepts; transfer when digit_valid & digit_ready on a rising edge.
- key_pressed  output  1  debounced button level, 1 = pressed.
- overrun  output  1  one-cycle pulse: press committed while buffer full and not draining; digit dropped.
- err_digit  output  1  one-cycle pulse: out-of-range digit rejected (see Optional Feature).

Behaviour:
- Reset is synchronous and active-high: reset reset, clock clk.
- Reset values:
  - Synchroniser flops: key = released (1), sw = 0.
  - FSM = IDLE, counter = 0, key_pressed = 0.
  - digit_valid = 0, digit_data = 0, overrun = 0, err_digit = 0.
- Synchronisers: two-flop chain on key_n_raw; two-flop chain per bit on sw_raw. All logic below uses the synchronised signals (key_s, sw_s).
- FSM states:
  - IDLE: key_pressed=0. key_s=0 -> PRESS_WAIT, counter=1.
  - PRESS_WAIT: key_s=1 -> IDLE, counter=0 (bounce reject). key_s=0 and counter==DEBOUNCE_CYCLES-1 -> PRESSED, commit press. Otherwise counter+1.
  - PRESSED: key_pressed=1. key_s=1 -> RELEASE_WAIT, counter=1.
  - RELEASE_WAIT: key_pressed=1. key_s=0 -> PRESSED, counter=0. key_s=1 and counter==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise counter+1.
  - Illegal encoding -> IDLE.
- Press commit (the PRESS_WAIT->PRESSED edge) captures sw_s of that same cycle:
  - Buffer empty, or digit_valid & digit_ready this cycle: load digit_data; digit_valid=1 next cycle.
  - Buffer full and digit_ready=0: buffer unchanged; overrun=1 for exactly one cycle.
- Handshake:
  - digit_valid & digit_ready with no commit -> digit_valid=0 next cycle; digit_data keeps its last value.
  - digit_data must not change while digit_valid=1, except on a simultaneous accept plus reload.
- Latency: with a clean press held from edge E0 (the first edge sampling key_n_raw=0), digit_valid rises after edge E0+DEBOUNCE_CYCLES+2. This means exactly one digit per press, none on release.
- Holding the button produces no repeat digits. A new digit requires a full debounced release followed by a new press.
- Reset asserted mid-debounce or with digit_valid=1: everything returns to reset values on the next edge, and any pending digit is discarded.
- No internal counter may wrap: the counter resets on every state change and never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: DIGIT_RANGE_CHECK_EN.
- Defined: at press commit, sw_s > 9 is not loaded. err_digit pulses one cycle, digit_valid and digit_data are unchanged, and overrun is not raised. This applies even when the buffer is full, in which case err_digit takes priority.
- Undefined: every value 0-15 is loaded normally and err_digit is tied to 0. The downstream FSM handles values 10-15 itself.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then key_n_raw held low from edge 0 with sw_raw=8 -> digit_valid=1 and digit_data=8 after edge 6; key_pressed=1; exactly one valid, consumed with digit_ready=1 for one cycle.
- Bounce: key_n_raw low 2 cycles, high 1, low 2, high -> no digit_valid and key_pressed stays 0; then a clean press with sw=3 -> one digit 3.
- Overrun: digit_ready=0, press sw=8, release, press sw=4 -> digit_data stays 8 and overrun pulses once on the second commit; then digit_ready=1 -> one transfer of 8 only.
- Simultaneous accept and commit: digit_valid=1 with data 2, digit_ready=1 on the commit cycle with sw=5 -> digit_valid stays 1, digit_data=5, no overrun.
- Reset asserted while in PRESS_WAIT with counter=2 and digit_valid=1 -> next edge all outputs 0, FSM IDLE; a continued key hold needs a full new debounce of DEBOUNCE_CYCLES cycles.
- With DIGIT_RANGE_CHECK_EN defined, press with sw=12 -> err_digit one-cycle pulse and digit_valid stays 0. Without the macro, the same press -> digit_valid=1 with digit_data=12.
